pe_fx_param: RTL and testbench

//  Parametrised fixed-point processing element; next generation of the array PE.

---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_fx_param_if.sv | 28 ++
 rtl/pe_mac_pipe.sv | 66 ++++++
 rtl/pe_fx_param.sv | 136 +++++++++++++
 tb/tb_pe_fx_param.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared opcodes, FSM encoding and default widths for the fixed-point PE family.
// Opcodes 6 and 7 are reserved and decode as NOP.
package pe_pkg;

    localparam int DATA_W_DEF    = 16;
    localparam int FRAC_W_DEF    = 8;
    localparam int ACC_W_DEF     = 40;
    localparam int WGT_DEPTH_DEF = 16;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_LOAD_WGT = 3'd1;
    localparam logic [2:0] OP_CLEAR    = 3'd2;
    localparam logic [2:0] OP_MAC      = 3'd3;
    localparam logic [2:0] OP_FLUSH    = 3'd4;
    localparam logic [2:0] OP_WGT_RST  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } state_t;

endpackage

// File: rtl/pe_fx_param_if.sv
// PE command/result bundle: sequencer (master) drives ops and output ready,
// PE (slave) returns the result handshake and status.
interface pe_fx_param_if import pe_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PTR_W  = 5
) ();
    logic [2:0]        ctrl;
    logic [DATA_W-1:0] data_in;
    logic              data_in_vld;
    logic              enable_act;
    logic              out_rdy;
    logic [DATA_W-1:0] data_out;
    logic              data_out_vld;
    logic              busy;
    logic [PTR_W-1:0]  wgt_count;
    logic [PTR_W-1:0]  rd_ptr;
    logic              err_flag;

    modport master (
        output ctrl, data_in, data_in_vld, enable_act, out_rdy,
        input  data_out, data_out_vld, busy, wgt_count, rd_ptr, err_flag
    );

    modport slave (
        input  ctrl, data_in, data_in_vld, enable_act, out_rdy,
        output data_out, data_out_vld, busy, wgt_count, rd_ptr, err_flag
    );
endinterface

// File: rtl/pe_mac_pipe.sv
// 2-stage signed MAC: product register, then sign-extended accumulate; res is acc >>> FRAC_W
// formatted to DATA_W (clamped if PE_SATURATE_EN, else low bits). No backpressure; clear wins.
module pe_mac_pipe import pe_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_vld,
    input  logic              in_acc,
    input  logic              clear,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              s1_vld,
    output logic [DATA_W-1:0] res
);
    localparam int PROD_W = 2 * DATA_W;

    logic                     s1_vld_q, s1_vld_d;
    logic                     s1_acc_q, s1_acc_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic        [ACC_W-1:0]  acc_q, acc_d;
    logic signed [PROD_W-1:0] a_ext, b_ext;

    always_comb begin
        a_ext    = {{DATA_W{a[DATA_W-1]}}, a};
        b_ext    = {{DATA_W{b[DATA_W-1]}}, b};
        prod_d   = a_ext * b_ext;
        s1_vld_d = in_vld && !clear;
        s1_acc_d = in_acc;
        acc_d    = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (s1_vld_q && s1_acc_q) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
        end
    end

    // Format is taken straight from acc_q slices so every accumulator bit stays live.
    always_comb begin
        res = acc_q[FRAC_W +: DATA_W];
`ifdef PE_SATURATE_EN
        if (!((&acc_q[ACC_W-1:FRAC_W+DATA_W-1]) || !(|acc_q[ACC_W-1:FRAC_W+DATA_W-1]))) begin
            res = acc_q[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_acc_q <= 1'b0;
            prod_q   <= '0;
            acc_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s1_acc_q <= s1_acc_d;
            prod_q   <= prod_d;
            acc_q    <= acc_d;
        end
    end

    assign s1_vld = s1_vld_q;

endmodule

// File: rtl/pe_fx_param.sv
// Fixed-point PE: weight buffer + 2-stage MAC, one ReLU-optional result per FLUSH (PE_SATURATE_EN clamps).
// Latency: FLUSH accepted at t -> data_out_vld at t+3; result held until out_rdy, ops ignored while busy.
module pe_fx_param import pe_pkg::*; #(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int WGT_DEPTH = WGT_DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    pe_fx_param_if.slave  bus
);
    localparam int PTR_W = $clog2(WGT_DEPTH + 1);
    localparam int IDX_W = $clog2(WGT_DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(WGT_DEPTH);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wgt_count_q, wgt_count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, rd_ptr_inc;
    logic              err_q, err_d;
    logic              relu_q, relu_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic [DATA_W-1:0] wgt_buf_q [WGT_DEPTH];
    logic [DATA_W-1:0] wgt_rd, acc_fmt;
    logic              wgt_wr, pipe_vld, pipe_acc, pipe_clr, pipe_busy, op_vld;

    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);
    assign wgt_rd     = wgt_buf_q[rd_ptr_q[IDX_W-1:0]];
    assign op_vld     = bus.data_in_vld && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        wgt_count_d = wgt_count_q;
        rd_ptr_d    = rd_ptr_q;
        err_d       = err_q;
        relu_d      = relu_q;
        data_out_d  = data_out_q;
        wgt_wr      = 1'b0;
        pipe_vld    = 1'b0;
        pipe_acc    = 1'b0;
        pipe_clr    = 1'b0;
        case (state_q)
            ST_IDLE: if (op_vld) begin
                case (bus.ctrl)
                    OP_LOAD_WGT: begin
                        if (wgt_count_q == DEPTH_P) begin
                            err_d = 1'b1;
                        end else begin
                            wgt_wr      = 1'b1;
                            wgt_count_d = wgt_count_q + PTR_W'(1);
                        end
                    end
                    OP_CLEAR: begin
                        pipe_clr = 1'b1;
                        rd_ptr_d = '0;
                    end
                    OP_MAC: begin
                        if (wgt_count_q == '0) begin
                            err_d = 1'b1;
                        end else begin
                            pipe_vld = 1'b1;
                            pipe_acc = 1'b1;
                            rd_ptr_d = (rd_ptr_inc == wgt_count_q) ? '0 : rd_ptr_inc;
                        end
                    end
                    // FLUSH rides the pipe as a non-accumulating token so drain time is fixed.
                    OP_FLUSH: begin
                        pipe_vld = 1'b1;
                        relu_d   = bus.enable_act;
                        state_d  = ST_DRAIN;
                    end
                    OP_WGT_RST: begin
                        wgt_count_d = '0;
                        rd_ptr_d    = '0;
                        err_d       = 1'b0;
                    end
                    default: ;
                endcase
            end
            ST_DRAIN: if (!pipe_busy) begin
                data_out_d = (relu_q && acc_fmt[DATA_W-1]) ? '0 : acc_fmt;
                state_d    = ST_OUT;
            end
            ST_OUT: if (bus.out_rdy) begin
                pipe_clr = 1'b1;
                rd_ptr_d = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wgt_count_q <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            relu_q      <= 1'b0;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            wgt_count_q <= wgt_count_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            relu_q      <= relu_d;
            data_out_q  <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wgt_wr) begin
            wgt_buf_q[wgt_count_q[IDX_W-1:0]] <= bus.data_in;
        end
    end

    pe_mac_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (pipe_vld),
        .in_acc (pipe_acc),
        .clear  (pipe_clr),
        .a      (bus.data_in),
        .b      (wgt_rd),
        .s1_vld (pipe_busy),
        .res    (acc_fmt)
    );

    assign bus.data_out     = data_out_q;
    assign bus.data_out_vld = (state_q == ST_OUT);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.wgt_count    = wgt_count_q;
    assign bus.rd_ptr       = rd_ptr_q;
    assign bus.err_flag     = err_q;

endmodule

// File: tb/tb_pe_fx_param.sv
// Directed bench for pe_fx_param (DATA_W=16, FRAC_W=8, WGT_DEPTH=4); expected values hand-computed.
module tb_pe_fx_param;
    import pe_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pe_fx_param_if #(.DATA_W(16), .PTR_W(3)) bus ();

    pe_fx_param #(.DATA_W(16), .FRAC_W(8), .ACC_W(40), .WGT_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

`ifdef PE_SATURATE_EN
    localparam logic [15:0] EXP_BIG = 16'h7FFF;
`else
    localparam logic [15:0] EXP_BIG = 16'h0300;
`endif

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [2:0] code, input logic [15:0] dat);
        bus.ctrl        = code;
        bus.data_in     = dat;
        bus.data_in_vld = 1'b1;
        tick();
        bus.data_in_vld = 1'b0;
        bus.ctrl        = OP_NOP;
    endtask

    task automatic wait_vld(output int lat);
        lat = 1;
        while (!bus.data_out_vld && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_flush(input logic act, input logic [15:0] exp, input string tag);
        int lat;
        bus.enable_act = act;
        op(OP_FLUSH, 16'h0000);
        bus.enable_act = 1'b0;
        wait_vld(lat);
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_dat"}, bus.data_out, exp);
        bus.out_rdy = 1'b1;
        tick();
        bus.out_rdy = 1'b0;
        chk({tag, "_vld_drop"}, bus.data_out_vld, 0);
        chk({tag, "_busy_drop"}, bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bus.ctrl        = OP_NOP;
        bus.data_in     = '0;
        bus.data_in_vld = 1'b0;
        bus.enable_act  = 1'b0;
        bus.out_rdy     = 1'b0;
        repeat (2) tick();
        chk("rst_dout", bus.data_out, 0);
        chk("rst_vld", bus.data_out_vld, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cnt", bus.wgt_count, 0);
        chk("rst_ptr", bus.rd_ptr, 0);
        chk("rst_err", bus.err_flag, 0);
        rst_n = 1'b1;
        tick();

        // 3.0*1.0 + 0.5*2.0 = 4.0
        op(OP_LOAD_WGT, 16'h0100);
        op(OP_LOAD_WGT, 16'h0200);
        chk("cnt2", bus.wgt_count, 2);
        op(OP_MAC, 16'h0300);
        chk("ptr_inc", bus.rd_ptr, 1);
        op(OP_MAC, 16'h0080);
        chk("ptr_wrap", bus.rd_ptr, 0);
        do_flush(1'b0, 16'h0400, "mac4");

        // -2.0 with and without ReLU
        op(OP_WGT_RST, 16'h0000);
        op(OP_LOAD_WGT, 16'h0100);
        op(OP_MAC, 16'hFE00);
        do_flush(1'b0, 16'hFE00, "neg_norelu");
        op(OP_MAC, 16'hFE00);
        do_flush(1'b1, 16'h0000, "neg_relu");

        // 3 * 127.0^2 overflows the 16-bit result
        op(OP_WGT_RST, 16'h0000);
        op(OP_LOAD_WGT, 16'h7F00);
        repeat (3) op(OP_MAC, 16'h7F00);
        do_flush(1'b0, EXP_BIG, "big");

        // weight buffer overflow and empty-buffer MAC
        op(OP_WGT_RST, 16'h0000);
        for (int i = 0; i < 5; i++) op(OP_LOAD_WGT, 16'h0010);
        chk("ovf_cnt", bus.wgt_count, 4);
        chk("ovf_err", bus.err_flag, 1);
        op(OP_WGT_RST, 16'h0000);
        chk("wrst_cnt", bus.wgt_count, 0);
        chk("wrst_err", bus.err_flag, 0);
        op(OP_MAC, 16'h0100);
        chk("mac0_err", bus.err_flag, 1);

        // output stall: result held, MACs ignored, acc cleared on handshake
        op(OP_WGT_RST, 16'h0000);
        op(OP_LOAD_WGT, 16'h0100);
        op(OP_LOAD_WGT, 16'h0100);
        op(OP_MAC, 16'h0100);
        chk("stall_ptr0", bus.rd_ptr, 1);
        op(OP_FLUSH, 16'h0000);
        wait_vld(lat);
        chk("stall_lat", lat, 3);
        bus.ctrl        = OP_MAC;
        bus.data_in     = 16'h0100;
        bus.data_in_vld = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_dat", bus.data_out, 16'h0100);
            chk("stall_vld", bus.data_out_vld, 1);
            chk("stall_busy", bus.busy, 1);
        end
        bus.data_in_vld = 1'b0;
        bus.ctrl        = OP_NOP;
        chk("stall_ptr_held", bus.rd_ptr, 1);
        bus.out_rdy = 1'b1;
        tick();
        bus.out_rdy = 1'b0;
        chk("stall_rel_vld", bus.data_out_vld, 0);
        chk("stall_rel_ptr", bus.rd_ptr, 0);
        do_flush(1'b0, 16'h0000, "post_stall");

        // asynchronous reset in DRAIN
        op(OP_MAC, 16'h0200);
        op(OP_FLUSH, 16'h0000);
        chk("drain_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", bus.data_out_vld, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_cnt", bus.wgt_count, 0);
        #2;
        rst_n = 1'b1;
        tick();
        do_flush(1'b0, 16'h0000, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
